pc_stack_unit: RTL and testbench

- Parametrised program-counter unit for the hrm-cpu core.
- Provides everything the existing 8-bit linear/jump counter does, plus:
  - configurable address width
  - configurable reset vector
  - signed PC-relative branches
  - CALL/RET backed by a hardware return-address stack
  - sticky fault reporting
- Sits between the control unit (which issues op/cond/en each instruction cycle) and program memory (addressed by pc).

---
 rtl/pc_stack_unit.sv | 130 +++++++++++++
 tb/tb_pc_stack_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program counter with linear/jump/relative-branch sequencing and a CALL/RET return-address stack.
// One-cycle registered update per en=1 instruction cycle; a sticky fault freezes all state until rst.
module pc_stack_unit #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        op,
  input  logic              cond,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic [ADDR_W-1:0] rel_off,
  output logic [ADDR_W-1:0] pc,
  output logic [SP_W-1:0]   sp,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BREL = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  localparam logic [1:0] FC_OVERFLOW  = 2'b01;
  localparam logic [1:0] FC_UNDERFLOW = 2'b10;
  localparam logic [1:0] FC_ILLEGAL   = 2'b11;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [SP_W-1:0]   sp_nxt;
  logic              fault_nxt;
  logic [1:0]        fault_code_nxt;
  logic              push;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign pc_inc      = pc + ADDR_W'(1);
  assign push_idx    = IDX_W'(sp);
  assign pop_idx     = IDX_W'(sp - SP_W'(1));

  // Faulting ops leave pc/sp untouched; only the first fault is latched.
  always_comb begin
    pc_nxt         = pc;
    sp_nxt         = sp;
    fault_nxt      = fault;
    fault_code_nxt = fault_code;
    push           = 1'b0;
    if (en && !fault) begin
      case (op)
        OP_INC:  pc_nxt = pc_inc;
        OP_JMP:  pc_nxt = cond ? jmp_addr : pc_inc;
        OP_BREL: pc_nxt = cond ? (pc + rel_off) : pc_inc;
        OP_CALL: begin
          if (!cond) begin
            pc_nxt = pc_inc;
          end else if (stack_full) begin
            fault_nxt      = 1'b1;
            fault_code_nxt = FC_OVERFLOW;
          end else begin
            push   = 1'b1;
            sp_nxt = sp + SP_W'(1);
            pc_nxt = jmp_addr;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            fault_nxt      = 1'b1;
            fault_code_nxt = FC_UNDERFLOW;
          end else begin
            pc_nxt = stack_mem[pop_idx];
            sp_nxt = sp - SP_W'(1);
          end
        end
        default: begin
          fault_nxt      = 1'b1;
          fault_code_nxt = FC_ILLEGAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= ADDR_W'(RESET_ADDR);
      sp         <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      pc         <= pc_nxt;
      sp         <= sp_nxt;
      fault      <= fault_nxt;
      fault_code <= fault_code_nxt;
    end
  end

  // Stack contents need no reset; sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

`ifdef FORMAL
  logic f_init;
  always_ff @(posedge clk) begin
    if (rst) f_init <= 1'b1;
  end

  always_comb begin
    if (f_init) assert (sp <= SP_W'(STACK_DEPTH));
  end

  assert property (@(posedge clk) $past(f_init) && $past(fault) && !$past(rst) |-> fault);
  assert property (@(posedge clk) $past(f_init) && !$past(en) && !$past(rst) |-> $stable(pc));
  cover property (@(posedge clk) f_init && pc == ADDR_W'(RESET_ADDR + 10));
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: vector table applied one cycle per entry plus a wrap sequence.
module tb_pc_stack_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] op;
  logic       cond;
  logic [7:0] jmp_addr;
  logic [7:0] rel_off;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       fault;
  logic [1:0] fault_code;

  int n_checks = 0;
  int n_errors = 0;

  pc_stack_unit #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .op         (op),
    .cond       (cond),
    .jmp_addr   (jmp_addr),
    .rel_off    (rel_off),
    .pc         (pc),
    .sp         (sp),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic       cond;
    logic [7:0] ja;
    logic [7:0] ro;
    logic [7:0] e_pc;
    logic [2:0] e_sp;
    logic       e_f;
    logic [1:0] e_c;
  } vec_t;

  vec_t vq[$];

  localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BREL = 3'd2, CALL = 3'd3, RET = 3'd4;

  function automatic vec_t mk(logic r, logic e, logic [2:0] o, logic c, logic [7:0] ja,
                              logic [7:0] ro, logic [7:0] epc, logic [2:0] esp,
                              logic ef, logic [1:0] ec);
    vec_t v;
    v.rst = r; v.en = e; v.op = o; v.cond = c; v.ja = ja; v.ro = ro;
    v.e_pc = epc; v.e_sp = esp; v.e_f = ef; v.e_c = ec;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic e, logic [2:0] o, logic c, logic [7:0] ja, logic [7:0] ro);
    rst = r; en = e; op = o; cond = c; jmp_addr = ja; rel_off = ro;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(string tag, logic [7:0] epc, logic [2:0] esp, logic ef, logic [1:0] ec);
    chk({tag, " pc"}, 32'(pc), 32'(epc));
    chk({tag, " sp"}, 32'(sp), 32'(esp));
    chk({tag, " fault"}, 32'(fault), 32'(ef));
    chk({tag, " code"}, 32'(fault_code), 32'(ec));
    chk({tag, " full"}, 32'(stack_full), 32'(esp == 3'd4));
    chk({tag, " empty"}, 32'(stack_empty), 32'(esp == 3'd0));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = INC; cond = 1'b0; jmp_addr = 8'h00; rel_off = 8'h00;

    // Reset, linear count, hold with en=0
    vq.push_back(mk(1, 0, INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    for (int k = 1; k <= 5; k++)
      vq.push_back(mk(0, 1, INC, 0, 8'h00, 8'h00, 8'(k), 0, 0, 0));
    vq.push_back(mk(0, 0, INC,  1, 8'h77, 8'h00, 8'h05, 0, 0, 0));
    vq.push_back(mk(1, 0, INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    // Jumps and relative branches
    vq.push_back(mk(0, 1, JMP,  1, 8'h10, 8'h00, 8'h10, 0, 0, 0));
    vq.push_back(mk(0, 1, JMP,  0, 8'h40, 8'h00, 8'h11, 0, 0, 0));
    vq.push_back(mk(0, 1, JMP,  1, 8'h40, 8'h00, 8'h40, 0, 0, 0));
    vq.push_back(mk(0, 1, BREL, 1, 8'h00, 8'hFC, 8'h3C, 0, 0, 0));
    vq.push_back(mk(0, 1, BREL, 0, 8'h00, 8'hFC, 8'h3D, 0, 0, 0));
    vq.push_back(mk(0, 1, JMP,  1, 8'hFE, 8'h00, 8'hFE, 0, 0, 0));
    vq.push_back(mk(0, 1, BREL, 1, 8'h00, 8'h05, 8'h03, 0, 0, 0));
    // Nested CALL/RET
    vq.push_back(mk(0, 1, JMP,  1, 8'h20, 8'h00, 8'h20, 0, 0, 0));
    vq.push_back(mk(0, 1, CALL, 1, 8'h80, 8'h00, 8'h80, 1, 0, 0));
    vq.push_back(mk(0, 1, CALL, 1, 8'h90, 8'h00, 8'h90, 2, 0, 0));
    vq.push_back(mk(0, 1, RET,  0, 8'h00, 8'h00, 8'h81, 1, 0, 0));
    vq.push_back(mk(0, 1, RET,  1, 8'h00, 8'h00, 8'h21, 0, 0, 0));
    vq.push_back(mk(0, 1, CALL, 0, 8'h55, 8'h00, 8'h22, 0, 0, 0));
    // Fill to depth, overflow, frozen while faulted
    vq.push_back(mk(0, 1, CALL, 1, 8'h10, 8'h00, 8'h10, 1, 0, 0));
    vq.push_back(mk(0, 1, CALL, 1, 8'h20, 8'h00, 8'h20, 2, 0, 0));
    vq.push_back(mk(0, 1, CALL, 1, 8'h30, 8'h00, 8'h30, 3, 0, 0));
    vq.push_back(mk(0, 1, CALL, 1, 8'h40, 8'h00, 8'h40, 4, 0, 0));
    vq.push_back(mk(0, 1, CALL, 1, 8'h50, 8'h00, 8'h40, 4, 1, 1));
    vq.push_back(mk(0, 1, INC,  0, 8'h00, 8'h00, 8'h40, 4, 1, 1));
    vq.push_back(mk(0, 1, RET,  0, 8'h00, 8'h00, 8'h40, 4, 1, 1));
    vq.push_back(mk(1, 0, INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    // Full-depth LIFO order
    vq.push_back(mk(0, 1, CALL, 1, 8'h10, 8'h00, 8'h10, 1, 0, 0));
    vq.push_back(mk(0, 1, CALL, 1, 8'h20, 8'h00, 8'h20, 2, 0, 0));
    vq.push_back(mk(0, 1, CALL, 1, 8'h30, 8'h00, 8'h30, 3, 0, 0));
    vq.push_back(mk(0, 1, CALL, 1, 8'h40, 8'h00, 8'h40, 4, 0, 0));
    vq.push_back(mk(0, 1, RET,  0, 8'h00, 8'h00, 8'h31, 3, 0, 0));
    vq.push_back(mk(0, 1, RET,  0, 8'h00, 8'h00, 8'h21, 2, 0, 0));
    vq.push_back(mk(0, 1, RET,  0, 8'h00, 8'h00, 8'h11, 1, 0, 0));
    vq.push_back(mk(0, 1, RET,  0, 8'h00, 8'h00, 8'h01, 0, 0, 0));
    // Underflow, illegal op, first fault wins
    vq.push_back(mk(1, 0, INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 1, RET,  0, 8'h00, 8'h00, 8'h00, 0, 1, 2));
    vq.push_back(mk(1, 0, INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 0, 3'd7, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 1, 3'd6, 0, 8'h00, 8'h00, 8'h00, 0, 1, 3));
    vq.push_back(mk(0, 1, RET,  0, 8'h00, 8'h00, 8'h00, 0, 1, 3));
    vq.push_back(mk(1, 0, INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 1, 3'd5, 1, 8'h00, 8'h00, 8'h00, 0, 1, 3));
    // rst beats a simultaneous CALL: no push, so the RET underflows
    vq.push_back(mk(1, 0, INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 1, JMP,  1, 8'h30, 8'h00, 8'h30, 0, 0, 0));
    vq.push_back(mk(1, 1, CALL, 1, 8'h80, 8'h00, 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 1, RET,  0, 8'h00, 8'h00, 8'h00, 0, 1, 2));
    vq.push_back(mk(1, 0, INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    // INC wraps from all-ones
    vq.push_back(mk(0, 1, JMP,  1, 8'hFF, 8'h00, 8'hFF, 0, 0, 0));
    vq.push_back(mk(0, 1, INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].en, vq[i].op, vq[i].cond, vq[i].ja, vq[i].ro);
      check_state($sformatf("v%0d", i), vq[i].e_pc, vq[i].e_sp, vq[i].e_f, vq[i].e_c);
    end

    // CALL from 0xFF pushes the wrapped return 0x00; it survives idle cycles
    drive(1, 0, INC, 0, 8'h00, 8'h00);
    drive(0, 1, JMP, 1, 8'hFF, 8'h00);
    check_state("wrap_jmp", 8'hFF, 3'd0, 1'b0, 2'd0);
    drive(0, 1, CALL, 1, 8'h60, 8'h00);
    check_state("wrap_call", 8'h60, 3'd1, 1'b0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, RET, 1, 8'hAA, 8'h55);
      check_state($sformatf("wrap_idle%0d", k), 8'h60, 3'd1, 1'b0, 2'd0);
    end
    drive(0, 1, RET, 0, 8'h00, 8'h00);
    check_state("wrap_ret", 8'h00, 3'd0, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
